// File: rtl/toggle_bank_arbiter.sv
// Toggle bank shared by NREQ requesters through a round-robin arbiter.
// Each clock at most one requester wins. The winner's indexed bit in q flips
// on the same edge that raises its one-hot grant.
// Optional feature: define TOGGLE_BANK_ARBITER_CLEAR_EN to add a synchronous
// clr input that zeroes the bank and suppresses the grant for that edge.
module toggle_bank_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*IDXW-1:0]   req_idx,
`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
    input  logic                   clr,
`endif
    output logic [NREQ-1:0]        gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   err,
    output logic                   busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [PW-1:0]    win;
    logic [IDXW-1:0]  win_idx;
    logic             idx_oob;

    // Round-robin search starting at the priority pointer, wrapping past NREQ-1.
    always_comb begin
        logic [PW:0] cand;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
    end

    // Only the winner's index matters; an index past the bank raises err.
    always_comb begin
        win_idx = req_idx[32'(win)*IDXW +: IDXW];
        idx_oob = (32'(win_idx) >= WIDTH);
    end

    // Next-state: grant, toggle, pointer advance; clr (when built) overrides.
    always_comb begin
        ptr_d  = ptr_q;
        gnt_d  = '0;
        q_d    = q_q;
        err_d  = 1'b0;
        busy_d = 1'b0;

        if (found) begin
            gnt_d  = NREQ'(1) << win;
            busy_d = 1'b1;
            err_d  = idx_oob;
            ptr_d  = (32'(win) == NREQ - 1) ? '0 : win + PW'(1);
            for (int b = 0; b < WIDTH; b++) begin
                if (!idx_oob && (32'(win_idx) == b)) begin
                    q_d[b] = ~q_q[b];
                end
            end
        end

`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
        // Clear wins over arbitration; pending requests simply retry next edge.
        if (clr) begin
            ptr_d  = ptr_q;
            gnt_d  = '0;
            q_d    = '0;
            err_d  = 1'b0;
            busy_d = 1'b0;
        end
`endif
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            gnt_q  <= '0;
            q_q    <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            q_q    <= q_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign q    = q_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// Bench for toggle_bank_arbiter (NREQ=4, WIDTH=8, IDXW=4).
// A behavioural model is checked against the DUT every cycle, and directed
// vectors carry hand-computed literal expectations.
module tb_toggle_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDXW  = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_idx;
`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
    logic        clr;
`endif
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    toggle_bank_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_idx (req_idx),
`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
        .clr     (clr),
`endif
        .gnt     (gnt),
        .q       (q),
        .err     (err),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: priority pointer as an integer, bank as a plain vector.
    int         m_ptr = 0;
    logic [3:0] m_gnt = '0;
    logic [7:0] m_q = '0;
    logic       m_err = 1'b0;
    logic       m_busy = 1'b0;
    bit         m_started = 1'b0;

    always @(posedge clk) begin
        int w;
        int idx;
        bit clear_now;
        clear_now = 1'b0;
`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
        clear_now = clr;
`endif
        m_started <= 1'b1;
        if (reset) begin
            m_ptr <= 0; m_gnt <= '0; m_q <= '0; m_err <= 1'b0; m_busy <= 1'b0;
        end else if (clear_now) begin
            m_gnt <= '0; m_q <= '0; m_err <= 1'b0; m_busy <= 1'b0;
        end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w < 0) begin
                m_gnt <= '0; m_err <= 1'b0; m_busy <= 1'b0;
            end else begin
                idx = int'(req_idx[w*IDXW +: IDXW]);
                m_gnt  <= 4'(1 << w);
                m_busy <= 1'b1;
                m_ptr  <= (w + 1) % NREQ;
                if (idx < WIDTH) begin
                    m_q   <= m_q ^ 8'(1 << idx);
                    m_err <= 1'b0;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Model comparison on every falling edge once the first edge has occurred.
    always @(negedge clk) begin
        if (m_started) begin
            check("model_gnt",  16'(gnt),  16'(m_gnt));
            check("model_q",    16'(q),    16'(m_q));
            check("model_err",  16'(err),  16'(m_err));
            check("model_busy", 16'(busy), 16'(m_busy));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] eg, input logic [7:0] eq,
                       input logic ee, input logic eb);
        check({name, "_gnt"},  16'(gnt),  16'(eg));
        check({name, "_q"},    16'(q),    16'(eq));
        check({name, "_err"},  16'(err),  16'(ee));
        check({name, "_busy"}, 16'(busy), 16'(eb));
    endtask

    logic [7:0] qseq [8];

    initial begin
        qseq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E, 8'h0C, 8'h08, 8'h00};
        reset = 1'b1; req = 4'b1111; req_idx = '0;
`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
        clr = 1'b0;
`endif
        // Reset held with all requests pending.
        repeat (3) begin
            cyc(); chk("reset", 4'b0000, 8'h00, 1'b0, 1'b0);
        end
        reset = 1'b0;
        cyc(); chk("first", 4'b0001, 8'h01, 1'b0, 1'b1);
        req = 4'b0000;
        cyc(); chk("idle0", 4'b0000, 8'h01, 1'b0, 1'b0);
        // Pointer is 1; lone req0 wins by wrapping and restores q.
        req = 4'b0001;
        cyc(); chk("wrap0", 4'b0001, 8'h00, 1'b0, 1'b1);

        // Single toggle of bit 2, then toggle back.
        req_idx = 16'h0002;
        cyc(); chk("tog2a", 4'b0001, 8'h04, 1'b0, 1'b1);
        req = 4'b0000;
        cyc(); chk("idle1", 4'b0000, 8'h04, 1'b0, 1'b0);
        req = 4'b0001;
        cyc(); chk("tog2b", 4'b0001, 8'h00, 1'b0, 1'b1);
        req = 4'b0000;
        cyc();

        // Out-of-range grant to req3 moves the pointer back to 0.
        req = 4'b1000; req_idx = 16'hF000;
        cyc(); chk("oob3", 4'b1000, 8'h00, 1'b1, 1'b1);
        req = 4'b0000;
        cyc(); chk("oob3_end", 4'b0000, 8'h00, 1'b0, 1'b0);

        // All four requesting for 8 cycles: strict rotation.
        req = 4'b1111; req_idx = 16'h3210;
        for (int i = 0; i < 8; i++) begin
            cyc(); chk("rotate", 4'(1 << (i % 4)), qseq[i], 1'b0, 1'b1);
        end
        req = 4'b0000;
        cyc();

        // req2 top bit, then an index past the bank.
        req = 4'b0100; req_idx = 16'h0700;
        cyc(); chk("idx7", 4'b0100, 8'h80, 1'b0, 1'b1);
        req = 4'b0000;
        cyc();
        req = 4'b0100; req_idx = 16'h0900;
        cyc(); chk("idx9", 4'b0100, 8'h80, 1'b1, 1'b1);
        req = 4'b0000;
        cyc(); chk("idx9_end", 4'b0000, 8'h80, 1'b0, 1'b0);

        // Pointer is 3; an out-of-range req0 grant moves it to 1.
        req = 4'b0001; req_idx = 16'h000F;
        cyc(); chk("oob0", 4'b0001, 8'h80, 1'b1, 1'b1);
        // req1 and req3 both name bit 5; serialised, each drops on grant.
        req = 4'b1010; req_idx = 16'h5050;
        cyc(); chk("same1", 4'b0010, 8'hA0, 1'b0, 1'b1);
        req = 4'b1000;
        cyc(); chk("same3", 4'b1000, 8'h80, 1'b0, 1'b1);
        req = 4'b0000;
        cyc(); chk("same_end", 4'b0000, 8'h80, 1'b0, 1'b0);

`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
        // Build q=A5, then clear with req0 pending.
        req = 4'b0001; req_idx = 16'h0000;
        cyc(); chk("bld0", 4'b0001, 8'h81, 1'b0, 1'b1);
        req_idx = 16'h0002;
        cyc(); chk("bld2", 4'b0001, 8'h85, 1'b0, 1'b1);
        req_idx = 16'h0005;
        cyc(); chk("bld5", 4'b0001, 8'hA5, 1'b0, 1'b1);
        req_idx = 16'h0000; clr = 1'b1;
        cyc(); chk("clr", 4'b0000, 8'h00, 1'b0, 1'b0);
        clr = 1'b0;
        cyc(); chk("after_clr", 4'b0001, 8'h01, 1'b0, 1'b1);
        req = 4'b0000;
        cyc();
`endif

        // Reset mid-activity returns the pointer to 0.
        req = 4'b1111; req_idx = 16'h3210; reset = 1'b1;
        cyc(); chk("reset2", 4'b0000, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(); chk("post_reset", 4'b0001, 8'h01, 1'b0, 1'b1);
        req = 4'b0000;
        cyc(); chk("final_idle", 4'b0000, 8'h01, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
